// File: rtl/traffic_unit.sv
// traffic_unit: per-node packet source for the NoC simulation.
// Descriptors {NumFlit, Vc, Dst} are queued by Fill, and a one-flit staging
// buffer feeds router input port 0, advanced by PreDeque/Dequeue.
// Optional build macro: TRAFFIC_COUNT_CHECK_EN -- when defined, `done` also
// waits until the number of Fills equals the total announced by Init.
module traffic_unit #(
    parameter int DEPTH = 1024,
    parameter int DST_W = 14,
    parameter int VC_W  = 4,
    parameter int NF_W  = 4,
    parameter int OP_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_W-1:0]         op,
    input  logic [31:0]             data,
    output logic                    done,
    output logic [VC_W+DST_W+2:0]   buffer
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DESC_W = DST_W + VC_W + NF_W;

    localparam logic [OP_W-1:0] OP_INIT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_FILL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DEQ   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_PREDQ = OP_W'(8);

    // Descriptor storage. Read is asynchronous so that a pop can present the
    // new head flit on the very edge that consumes the previous tail.
    logic [DESC_W-1:0] r_mem [DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic [VC_W-1:0]   r_vc;
    logic              r_head, r_tail;
    logic [DST_W-1:0]  r_dst;
    logic [NF_W-1:0]   r_nflit;
    logic [NF_W-1:0]   r_idx;
    logic [9:0]        r_expected, r_filled;
    logic              r_done;

    logic [PTR_W-1:0]  w_rd_ptr_next, w_wr_ptr_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_full_next;
    logic [VC_W-1:0]   w_vc_next;
    logic              w_head_next, w_tail_next;
    logic [DST_W-1:0]  w_dst_next;
    logic [NF_W-1:0]   w_nflit_next;
    logic [NF_W-1:0]   w_idx_next;
    logic [9:0]        w_expected_next, w_filled_next;
    logic              w_done_next;

    logic              w_q_empty, w_q_full, w_push, w_load;
    logic [DESC_W-1:0] w_head_desc;
    logic [NF_W-1:0]   w_desc_nf, w_desc_nf_eff, w_idx_inc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_q_empty     = (r_count == '0);
    assign w_q_full      = (r_count == CNT_W'(DEPTH));
    assign w_push        = (op == OP_FILL) && !w_q_full;
    assign w_head_desc   = r_mem[r_rd_ptr];
    assign w_desc_nf     = w_head_desc[DESC_W-1:DST_W+VC_W];
    // A zero flit count still describes a real packet: treat it as one flit.
    assign w_desc_nf_eff = (w_desc_nf == '0) ? NF_W'(1) : w_desc_nf;
    assign w_idx_inc     = r_idx + NF_W'(1);

    // Descriptor RAM write port; Fill on a full queue is silently dropped.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data[DESC_W-1:0];
        end
    end

    // Command decode: next queue pointers, staging buffer and bookkeeping.
    always_comb begin
        w_rd_ptr_next   = r_rd_ptr;
        w_wr_ptr_next   = r_wr_ptr;
        w_count_next    = r_count;
        w_full_next     = r_full;
        w_vc_next       = r_vc;
        w_head_next     = r_head;
        w_tail_next     = r_tail;
        w_dst_next      = r_dst;
        w_nflit_next    = r_nflit;
        w_idx_next      = r_idx;
        w_expected_next = r_expected;
        w_filled_next   = r_filled;
        w_load          = 1'b0;

        case (op)
            OP_INIT: begin
                w_rd_ptr_next   = '0;
                w_wr_ptr_next   = '0;
                w_count_next    = '0;
                w_full_next     = 1'b0;
                w_vc_next       = '0;
                w_head_next     = 1'b0;
                w_tail_next     = 1'b0;
                w_dst_next      = '0;
                w_nflit_next    = '0;
                w_idx_next      = '0;
                w_expected_next = data[31:22];
                w_filled_next   = '0;
            end
            OP_FILL: begin
                if (w_push) begin
                    w_wr_ptr_next = ptr_inc(r_wr_ptr);
                    w_count_next  = r_count + CNT_W'(1);
                    w_filled_next = r_filled + 10'd1;
                end
            end
            OP_PREDQ: begin
                if (!r_full && !w_q_empty) begin
                    w_load = 1'b1;
                end
            end
            OP_DEQ: begin
                if (r_full) begin
                    if (!r_tail) begin
                        w_idx_next  = w_idx_inc;
                        w_head_next = 1'b0;
                        w_tail_next = (w_idx_inc == r_nflit - NF_W'(1));
                    end else if (!w_q_empty) begin
                        // Back-to-back packets: next head flit with no bubble.
                        w_load = 1'b1;
                    end else begin
                        w_full_next  = 1'b0;
                        w_vc_next    = '0;
                        w_head_next  = 1'b0;
                        w_tail_next  = 1'b0;
                        w_dst_next   = '0;
                        w_nflit_next = '0;
                        w_idx_next   = '0;
                    end
                end
            end
            default: ;
        endcase

        if (w_load) begin
            w_rd_ptr_next = ptr_inc(r_rd_ptr);
            w_count_next  = r_count - CNT_W'(1);
            w_full_next   = 1'b1;
            w_dst_next    = w_head_desc[DST_W-1:0];
            w_vc_next     = w_head_desc[DST_W+VC_W-1:DST_W];
            w_nflit_next  = w_desc_nf_eff;
            w_idx_next    = '0;
            w_head_next   = 1'b1;
            w_tail_next   = (w_desc_nf_eff == NF_W'(1));
        end

`ifdef TRAFFIC_COUNT_CHECK_EN
        w_done_next = !w_full_next && (w_count_next == '0) &&
                      (w_filled_next == w_expected_next);
`else
        w_done_next = !w_full_next && (w_count_next == '0);
`endif
    end

    // State registers; reset empties the queue and clears the staging buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_vc       <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_dst      <= '0;
            r_nflit    <= '0;
            r_idx      <= '0;
            r_expected <= '0;
            r_filled   <= '0;
            r_done     <= 1'b1;
        end else begin
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_count    <= w_count_next;
            r_full     <= w_full_next;
            r_vc       <= w_vc_next;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_dst      <= w_dst_next;
            r_nflit    <= w_nflit_next;
            r_idx      <= w_idx_next;
            r_expected <= w_expected_next;
            r_filled   <= w_filled_next;
            r_done     <= w_done_next;
        end
    end

    assign buffer = {r_full, r_vc, r_head, r_tail, r_dst};
    assign done   = r_done;

endmodule

// File: tb/tb_traffic_unit.sv
// Testbench for traffic_unit: directed scenarios followed by random commands.
// A reference model (descriptor queue + expanded flit list) predicts
// {done, buffer} for every command; a monitor compares after each edge.
module tb_traffic_unit;

    localparam logic [3:0] NOP = 4'd0, INIT = 4'd5, FILL = 4'd6, DEQ = 4'd7, PRE = 4'd8;

    logic        clk;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] data;
    logic        done;
    logic [20:0] buffer;

    traffic_unit dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .data   (data),
        .done   (done),
        .buffer (buffer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [21:0] exp;
    } sb_t;

    sb_t         sbq[$];
    logic [21:0] m_desc[$];
    logic [20:0] m_flits[$];
    int          m_expected;
    int          m_filled;
    int          n_tests;
    int          n_fail;
    int          n_txn;

    // Reference model: a packet is expanded into its whole flit list on pop.
    function automatic void load_next();
        logic [21:0] d;
        int n;
        d = m_desc.pop_front();
        n = int'(d[21:18]);
        if (n == 0) n = 1;
        for (int i = 0; i < n; i++)
            m_flits.push_back({1'b1, d[17:14], (i == 0), (i == n - 1), d[13:0]});
    endfunction

    function automatic logic model_done();
        logic d;
        d = (m_flits.size() == 0) && (m_desc.size() == 0);
`ifdef TRAFFIC_COUNT_CHECK_EN
        d = d && (m_filled == m_expected);
`endif
        return d;
    endfunction

    function automatic logic [21:0] model_out();
        logic [20:0] b;
        b = (m_flits.size() > 0) ? m_flits[0] : 21'd0;
        return {model_done(), b};
    endfunction

    function automatic void model_reset();
        m_desc.delete();
        m_flits.delete();
        m_expected = 0;
        m_filled   = 0;
    endfunction

    function automatic void model_step(input logic [3:0] o, input logic [31:0] d);
        case (o)
            INIT: begin
                m_desc.delete();
                m_flits.delete();
                m_expected = int'(d[31:22]);
                m_filled   = 0;
            end
            FILL: begin
                if (m_desc.size() < 1024) begin
                    m_desc.push_back(d[21:0]);
                    m_filled = (m_filled + 1) % 1024;
                end
            end
            PRE: begin
                if (m_flits.size() == 0 && m_desc.size() > 0) load_next();
            end
            DEQ: begin
                if (m_flits.size() > 0) begin
                    void'(m_flits.pop_front());
                    if (m_flits.size() == 0 && m_desc.size() > 0) load_next();
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] fdesc(input int dst, input int vc, input int nf);
        logic [13:0] f_d;
        logic [3:0]  f_v;
        logic [3:0]  f_n;
        f_d = dst[13:0];
        f_v = vc[3:0];
        f_n = nf[3:0];
        return {10'd0, f_n, f_v, f_d};
    endfunction

    function automatic logic [20:0] flit(input int vc, input bit h, input bit t, input int dst);
        logic [13:0] f_d;
        logic [3:0]  f_v;
        f_d = dst[13:0];
        f_v = vc[3:0];
        return {1'b1, f_v, h, t, f_d};
    endfunction

    task automatic chk(input string name, input logic [21:0] got, input logic [21:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got done=%0b buffer=%06h, expected done=%0b buffer=%06h",
                     name, got[21], got[20:0], exp[21], exp[20:0]);
        end else begin
            $display("[TB] check %s ok: done=%0b buffer=%06h", name, got[21], got[20:0]);
        end
    endtask

    // Drive one command at the falling edge and record the predicted result.
    task automatic cmd(input logic [3:0] o, input logic [31:0] d);
        sb_t e;
        @(negedge clk);
        op   = o;
        data = d;
        model_step(o, d);
        e.op  = o;
        e.exp = model_out();
        sbq.push_back(e);
    endtask

    task automatic cmd_chk(input string name, input logic [3:0] o, input logic [31:0] d,
                           input logic exp_done, input logic [20:0] exp_buf);
        cmd(o, d);
        @(posedge clk);
        #2;
        chk(name, {done, buffer}, {exp_done, exp_buf});
    endtask

    // Monitor: the DUT presents a new result after every edge that carried a command.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_txn++;
                n_tests++;
                if ({done, buffer} !== e.exp) begin
                    n_fail++;
                    $display("[TB] FAIL txn%0d op=%0d: got done=%0b buffer=%06h, expected done=%0b buffer=%06h",
                             n_txn, e.op, done, buffer, e.exp[21], e.exp[20:0]);
                end else begin
                    $display("[TB] txn%0d op=%0d done=%0b buffer=%06h", n_txn, e.op, done, buffer);
                end
            end
        end
    end

    initial begin
        logic       cnt_done;
        int         r;
        logic [3:0] o;
        logic [31:0] d;

        n_tests = 0;
        n_fail  = 0;
        n_txn   = 0;
        op      = NOP;
        data    = '0;
        rst     = 1'b1;
        model_reset();
        #22;
        chk("reset_state", {done, buffer}, {1'b1, 21'd0});
        @(negedge clk);
        rst = 1'b0;

        // Init with total 0: idle and done.
        cmd_chk("init0", INIT, 32'd0, 1'b1, 21'd0);

        // One three-flit packet.
        cmd(INIT, 32'(1) << 22);
        cmd(FILL, fdesc(3, 1, 3));
        cmd_chk("pkt3_head", PRE, 32'd0, 1'b0, flit(1, 1, 0, 3));
        cmd_chk("pkt3_body", DEQ, 32'd0, 1'b0, flit(1, 0, 0, 3));
        cmd_chk("pkt3_tail", DEQ, 32'd0, 1'b0, flit(1, 0, 1, 3));
        cmd_chk("pkt3_drain", DEQ, 32'd0, 1'b1, 21'd0);

        // Two single-flit packets back to back, no bubble.
        cmd(INIT, 32'(2) << 22);
        cmd(FILL, fdesc(5, 0, 1));
        cmd(FILL, fdesc(9, 0, 1));
        cmd_chk("b2b_first", PRE, 32'd0, 1'b0, flit(0, 1, 1, 5));
        cmd_chk("b2b_second", DEQ, 32'd0, 1'b0, flit(0, 1, 1, 9));
        cmd_chk("b2b_drain", DEQ, 32'd0, 1'b1, 21'd0);
        cmd_chk("deq_empty", DEQ, 32'd0, 1'b1, 21'd0);

        // NumFlit=0 behaves as a single flit.
        cmd(INIT, 32'(1) << 22);
        cmd(FILL, fdesc(7, 2, 0));
        cmd_chk("nf0_flit", PRE, 32'd0, 1'b0, flit(2, 1, 1, 7));
        cmd_chk("nf0_drain", DEQ, 32'd0, 1'b1, 21'd0);

        // Announced total of 2 with only one Fill drained.
`ifdef TRAFFIC_COUNT_CHECK_EN
        cnt_done = 1'b0;
`else
        cnt_done = 1'b1;
`endif
        cmd(INIT, 32'(2) << 22);
        cmd(FILL, fdesc(4, 0, 1));
        cmd(PRE, 32'd0);
        cmd_chk("count_partial", DEQ, 32'd0, cnt_done, 21'd0);
        cmd(FILL, fdesc(6, 0, 1));
        cmd(PRE, 32'd0);
        cmd_chk("count_complete", DEQ, 32'd0, 1'b1, 21'd0);

        // Asynchronous reset mid-packet.
        cmd(INIT, 32'(1) << 22);
        cmd(FILL, fdesc(3, 1, 4));
        cmd(PRE, 32'd0);
        cmd(DEQ, 32'd0);
        @(posedge clk);
        #3;
        op = NOP;
        rst = 1'b1;
        #1;
        chk("async_reset", {done, buffer}, {1'b1, 21'd0});
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Queue capacity: the 1025th Fill is dropped.
        cmd(INIT, 32'(1024) << 22);
        for (int i = 0; i < 1024; i++) cmd(FILL, fdesc(i + 100, i % 16, 1));
        cmd(FILL, fdesc(16383, 15, 1));
        cmd(PRE, 32'd0);
        for (int i = 0; i < 1024; i++) cmd(DEQ, 32'd0);
        @(posedge clk);
        #2;
        chk("overflow_drained", {done, buffer}, {1'b1, 21'd0});

        // Random commands against the reference model.
        cmd(INIT, 32'($urandom_range(0, 40)) << 22);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            d = $urandom;
            if (r < 30)      o = FILL;
            else if (r < 45) o = PRE;
            else if (r < 85) o = DEQ;
            else if (r < 87) o = INIT;
            else if (r < 93) o = NOP;
            else             o = 4'($urandom_range(9, 15));
            if (o == INIT) d = {10'($urandom_range(0, 40)), d[21:0]};
            cmd(o, d);
        end

        @(negedge clk);
        op = NOP;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_unit.md
# traffic_unit

Per-node packet source for the NoC simulation. The testbench driver preloads it with packet descriptors (destination, VC, flit count). It then presents one flit at a time on a staging buffer that feeds input port 0 of the attached router. The driver pops flits with `Dequeue` whenever the router can accept the flit's VC. One instance sits beside each router.

## Interface
Parameters:
- `DEPTH`, 1024: descriptor queue depth (`NumPackets`).
- `DST_W`, 14: destination field width (`DestSize`).
- `VC_W`, 4: VC field width.
- `NF_W`, 4: flit-count field width.
- `OP_W`, 4: opcode width.

Ports (module name `traffic_unit`):
- `clk`, in, 1: single clock, all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `op`, in, `OP_W`: command. NOP=0, Init=5, Fill=6, Dequeue=7, PreDeque=8; other codes behave as NOP.
- `data`, in, 32: command payload.
  - Fill: Dst [13:0], Vc [17:14], NumFlit [21:18].
  - Init: TotalNumTraffic [31:22].
- `done`, out, 1: every loaded packet has been fully dequeued.
- `buffer`, out, 21: current flit, packed {Full[20], Vc[19:16], Head[15], Tail[14], Dst[13:0]}.

## Operation
- Internal state:
  - circular descriptor queue (rd/wr pointers plus count);
  - current-packet register (dst, vc, nflit);
  - flit index counter;
  - 10-bit `expected` total and `filled` count.
- Init: flush queue and pointers; clear `buffer`; flit index=0; `expected`=data[31:22]; `filled`=0.
- Fill: push {Dst, Vc, NumFlit} and increment `filled`. A Fill while the queue is full is dropped and changes nothing.
- PreDeque: if `buffer.Full`=0 and queue not empty, pop the head descriptor into `buffer` as flit 0. Otherwise no effect.
- Flit encoding:
  - Head=1 iff index==0.
  - Tail=1 iff index==nflit-1.
  - Dst and Vc come from the descriptor.
  - Full=1 while a flit is presented.
  - NumFlit=0 is treated as 1, so single-flit packets have Head=Tail=1.
- Dequeue with `buffer.Full`=1:
  - If Tail=0: index+1; Head drops to 0; Tail is recomputed.
  - If Tail=1 and queue not empty: pop the next descriptor and present its flit 0 (no bubble).
  - If Tail=1 and queue empty: `buffer` becomes all zeros.
- Dequeue with `buffer.Full`=0: no effect.
- `done` = (`buffer.Full`==0) && (queue empty).
- Multi-flit packets are never interleaved; a new descriptor is loaded only after Tail is dequeued.

## Timing
- All outputs are registered. A command issued in cycle N is visible after the rising edge ending cycle N (latency 1).
- One command per cycle. Back-to-back Dequeue yields one flit per cycle, including across packet boundaries.
- Reset, asynchronous and effective mid-operation:
  - queue empty; `buffer`=0; `done`=1;
  - `expected`=0; `filled`=0.
- Pointers wrap modulo `DEPTH`. Full is count==DEPTH; empty is count==0.
- Fill on the same edge as queue-empty does not make Dequeue pop; only the state before the edge counts.

## Configuration
- `TRAFFIC_COUNT_CHECK_EN`:
  - Defined: `done` additionally requires `filled`==`expected`. Until the announced number of Fills has arrived, `done` stays 0 even when the queue and buffer are empty.
  - Undefined: `expected` is stored but unused, and `done` is as in Operation.

## Test plan
- Reset, then Init with total=0: `done`=1 and `buffer`=0.
- Init total=1; Fill Dst=3, Vc=1, NumFlit=3; PreDeque:
  - `buffer` = Full=1, Vc=1, Head=1, Tail=0, Dst=3.
  - Two Dequeues give Head=0 Tail=0, then Head=0 Tail=1.
  - A third Dequeue gives `buffer`=0 and `done`=1.
- Fill two 1-flit packets (Dst 5, then Dst 9), PreDeque, Dequeue: the second edge shows Dst=9 with Head=Tail=1 and no empty cycle.
- Dequeue with an empty buffer: no state change. Fill 1025 descriptors: the 1025th is dropped; count stays 1024.
- NumFlit=0 descriptor: presented as a single flit with Head=Tail=1.
- With `TRAFFIC_COUNT_CHECK_EN`: Init total=2, one Fill, drain: `done`=0 until the second Fill is drained. Assert `rst` mid-packet: `buffer`=0 immediately.
